uart_32bit_tx: RTL
==================

UART_32BIT_TX -- requirements
Module: uart_32bit_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 resets on next rising clk edge).
REQ-004 SHALL have port data_in  input  32  word to transmit, sampled only on the accepting edge.
REQ-005 SHALL have port data_start  input  1  request; accepted only when block idle.
REQ-006 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-007 SHALL have port busy  output  1  high from acceptance through the data_end cycle inclusive.
REQ-008 SHALL have port data_end  output  1  single-cycle pulse, word fully sent.

Function
REQ-009 SHALL use frame format 8N1 per byte: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-010 SHALL send bytes in order data_in[7:0], [15:8], [23:16], [31:24], matching uart_32bit_rx assembly order.
REQ-011 SHALL use states IDLE, START, DATA, STOP, DONE, with a 2-bit byte index and 3-bit bit index.
REQ-012 IDLE: tx=1, busy=0; on edge k with data_start=1, latch data_in into a 32-bit shadow register, clear byte index, go to START.
REQ-013 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-014 DATA: tx = current byte bit[bit index], each held exactly CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-015 STOP: tx=1 for exactly CLKS_PER_BIT cycles; then START of next byte if byte index < 3 (index increments, no idle gap), else DONE.
REQ-016 DONE: one cycle, data_end=1, busy=1, tx=1; then IDLE.
REQ-017 Latency: tx first low in the cycle after edge k; data_end high only in the cycle after edge k+40*CLKS_PER_BIT.
REQ-018 Baud counter SHALL be 16 bits, reload 0 at each bit boundary, bit advance when counter == CLKS_PER_BIT-1.
REQ-019 data_start while busy=1 (including the DONE cycle) SHALL be ignored, not queued.
REQ-020 data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-021 data_start held high continuously SHALL start a new word on the first IDLE cycle after DONE (one idle cycle between words).

Reset
REQ-022 On reset=0 at any edge, including mid-frame: state IDLE, tx=1, busy=0, data_end=0, counters and shadow register cleared, effective at that edge.
REQ-023 data_start SHALL be ignored during any cycle reset=0; first acceptance possible on the first edge with reset=1.

Verification (CLKS_PER_BIT=4)
REQ-024 data_in=0x12345678, pulse data_start -> byte stream 0x78,0x56,0x34,0x12; first frame tx = 0,0,0,0,1,1,1,1,0,1 each 4 cycles; data_end one cycle after 160 bit-cycles; busy falls next cycle.
REQ-025 data_in=0x00000000 then 0xFFFFFFFF back-to-back with data_start held high -> both words correct, exactly one tx=1 idle cycle between DONE and next start bit.
REQ-026 data_start pulsed and data_in changed to 0xDEADBEEF mid-frame of 0xA5A5A5A5 -> transmitted bytes remain A5 x4, single data_end.
REQ-027 reset=0 asserted during bit 3 of byte 2 -> tx=1, busy=0 after that edge, no data_end; subsequent word 0xCAFEBABE sent correctly.
REQ-028 Loopback tx into uart_32bit_rx with matched baud, random 1000 words -> every data_out equals sent data_in.

Source files
------------

// File: rtl/uart_32bit_tx.sv
// 32-bit word serializer: four 8N1 UART frames, byte 0 first, each bit held
// CLKS_PER_BIT clocks. busy covers acceptance through the one-cycle data_end.
module uart_32bit_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        data_start,
    output logic        tx,
    output logic        busy,
    output logic        data_end
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  byte_idx, byte_n;
    logic [2:0]  bit_idx, bit_n;
    logic [31:0] shadow, shadow_n;
    logic        tx_n;
    logic        bit_done;

    assign bit_done = (cnt == LAST);
    assign busy     = (state != IDLE);
    assign data_end = (state == DONE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 16'd1;
        byte_n   = byte_idx;
        bit_n    = bit_idx;
        shadow_n = shadow;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (data_start) begin
                    shadow_n = data_in;
                    byte_n   = '0;
                    bit_n    = '0;
                    state_n  = START;
                end
            end
            START: if (bit_done) begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = DATA;
            end
            DATA: if (bit_done) begin
                cnt_n = '0;
                if (bit_idx == 3'd7) state_n = STOP;
                else                 bit_n   = bit_idx + 3'd1;
            end
            STOP: if (bit_done) begin
                cnt_n = '0;
                if (byte_idx != 2'd3) begin
                    byte_n  = byte_idx + 2'd1;
                    state_n = START;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // tx is registered, so it is decoded from the upcoming state
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shadow_n[{byte_n, bit_n}];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            shadow   <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            byte_idx <= byte_n;
            bit_idx  <= bit_n;
            shadow   <= shadow_n;
            tx       <= tx_n;
        end
    end

endmodule
